calc_frame_sequencer: RTL and testbench
=======================================

# calc_frame_sequencer

Byte-stream front end for the calculator datapath. It receives 3-byte request frames on a valid/ready byte interface and drives the calculator's operand and opcode inputs from registers. It samples the calculator's combinational result and error flag, then returns a 3-byte response frame on a second valid/ready byte interface. It sits between the host byte link and the calculator, acting as the initiator of every calculator operation.

## Interface
- IDLE_TIMEOUT, 255: consecutive cycles without an accepted byte, mid-frame, before the partial frame is aborted. Legal range 1..255; the counter is 8 bits.

- clk  in  1  single clock; rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx_data  in  8  request byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  sequencer can accept a request byte.
- tx_data  out  8  response byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  sink accepts tx_data.
- calc_a  out  8  operand A to the calculator.
- calc_b  out  8  operand B to the calculator.
- calc_opcode  out  2  00 add, 01 sub, 10 mul, 11 div.
- calc_result  in  16  calculator result (combinational from calc_a/calc_b/calc_opcode).
- calc_error  in  1  calculator error flag (divide by zero).
- busy  out  1  high whenever state is not IDLE.
- frame_err  out  1  one-cycle pulse on a dropped header or a timeout abort.

## Operation
- States: IDLE, GET_A, GET_B, EXEC, SEND_S, SEND_H, SEND_L. All outputs are registered.
- Byte transfer: a byte moves on any rising edge with valid & ready. Applies to both rx and tx.
- IDLE, accepted byte checked as a header:
  - Valid header: bits[7:4] = 4'hA and bits[3:2] = 2'b00. Action: calc_opcode <= bits[1:0], then go to GET_A.
  - Any other byte: drop it, pulse frame_err, stay in IDLE.
- GET_A: on an accepted byte, calc_a <= rx_data, then go to GET_B.
- GET_B: on an accepted byte, calc_b <= rx_data, then go to EXEC.
- EXEC: exactly one cycle. At its closing edge:
  - res_q <= calc_result and err_q <= calc_error.
  - If calc_error = 1, res_q <= 16'h0000. This forces a defined value in place of the calculator's X output.
  - Next state is SEND_S.
- Response bytes, in order:
  - SEND_S: status = {4'h5, 1'b0, err_q, calc_opcode}.
  - SEND_H: res_q[15:8].
  - SEND_L: res_q[7:0].
  - After SEND_L is accepted, return to IDLE.
- tx_valid rules:
  - tx_valid = 1 in the SEND_* states only.
  - tx_data is stable and tx_valid stays high until the byte is accepted. No retraction.
- rx_ready rules:
  - rx_ready = 1 in IDLE, GET_A and GET_B; 0 in EXEC and SEND_*.
  - Requests are strictly one at a time; there is no overlap with the response.
- Arithmetic: results pass through unmodified. Subtraction wraps modulo 2^16, so 3-5 = 16'hFFFE.
- calc_a, calc_b and calc_opcode hold their values between frames.
- Timeout:
  - An 8-bit counter runs in GET_A/GET_B. It clears on state entry and on every accepted byte.
  - After IDLE_TIMEOUT consecutive cycles without an accepted byte: go to IDLE and pulse frame_err.
  - A byte accepted on the timeout cycle wins: it is taken and no abort occurs.
- Reset mid-operation:
  - Any partial request is discarded.
  - Any response in flight is abandoned; tx_valid falls immediately.

## Timing
- Reset values:
  - tx_valid, tx_data, calc_a, calc_b, calc_opcode, busy, frame_err, rx_ready = 0.
  - State = IDLE; res_q, err_q and the counter = 0.
  - rx_ready rises at the first rising edge after rst deasserts.
- Latency: B accepted at edge k gives EXEC during cycle k..k+1. tx_valid is high with the status byte from edge k+1.
- Minimum frame turnaround is 7 cycles: 3 rx + 1 EXEC + 3 tx, with no stalls.
- frame_err is high for exactly the one cycle after the edge that drops the header or aborts the frame.
- busy rises with the header-accept edge and falls with the SEND_L-accept edge.

## Test plan
- Add: rx A0,12,34 with tx_ready=1 -> tx 50,00,46; frame_err never set; status appears 1 cycle after 34 is accepted.
- Mul with backpressure: rx A2,FF,FF, tx_ready low 5 cycles during SEND_H -> tx 52,FE,01; tx_data=FE and tx_valid held for all stall cycles.
- Div: rx A3,64,07 -> 53,00,0E. Then rx A3,07,00 -> 57,00,00 with the error bit set.
- Sub wrap: rx A1,03,05 -> 51,FF,FE.
- Framing errors:
  - rx 30 then A4 -> both dropped, two frame_err pulses, no tx.
  - rx A0,01, then rx_valid low 255 cycles -> frame_err pulse, busy=0.
  - Then A0,01,01 -> 50,00,02.
  - Byte arriving on the 255th cycle -> accepted, no abort.
- Reset mid-response: assert rst after the status byte is accepted -> tx_valid=0 and busy=0 asynchronously. rx_ready=0 until the first edge after release, then 1. The next frame A0,02,02 -> 50,00,04.

Source files
------------

// File: rtl/calc_frame_sequencer_if.sv
// Byte-link and calculator-side signals of the frame sequencer.
// The master modport is the sequencer; the slave modport is its environment.
`timescale 1ns/1ps
interface calc_frame_sequencer_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  calc_a;
    logic [7:0]  calc_b;
    logic [1:0]  calc_opcode;
    logic [15:0] calc_result;
    logic        calc_error;
    logic        busy;
    logic        frame_err;

    modport master (
        input  rx_data, rx_valid, tx_ready, calc_result, calc_error,
        output rx_ready, tx_data, tx_valid, calc_a, calc_b, calc_opcode, busy, frame_err
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, calc_result, calc_error,
        input  rx_ready, tx_data, tx_valid, calc_a, calc_b, calc_opcode, busy, frame_err
    );
endinterface

// File: rtl/calc_frame_sequencer.sv
// Receives 3-byte request frames, drives the calculator from registers and
// returns a 3-byte response frame (status, result high, result low).
`timescale 1ns/1ps
module calc_frame_sequencer #(
    parameter int unsigned IDLE_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    calc_frame_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_GET_A, S_GET_B, S_EXEC, S_SEND_S, S_SEND_H, S_SEND_L
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(IDLE_TIMEOUT - 1);

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_cnt, w_cnt_nxt;
    logic [15:0] r_res_q, w_res_nxt;
    logic        r_err_q, w_err_nxt;
    logic [7:0]  r_calc_a, w_calc_a_nxt;
    logic [7:0]  r_calc_b, w_calc_b_nxt;
    logic [1:0]  r_opcode, w_opcode_nxt;
    logic [7:0]  r_tx_data, w_tx_data_nxt;
    logic        r_tx_valid, r_rx_ready, r_busy, r_frame_err;
    logic        w_frame_err_nxt;
    logic        w_rx_fire, w_tx_fire;

    assign w_rx_fire = bus.rx_valid & r_rx_ready;
    assign w_tx_fire = r_tx_valid & bus.tx_ready;

    // NOTE: every signal gets its default first so no path leaves one unassigned (no latches).
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = 8'd0;
        w_res_nxt       = r_res_q;
        w_err_nxt       = r_err_q;
        w_calc_a_nxt    = r_calc_a;
        w_calc_b_nxt    = r_calc_b;
        w_opcode_nxt    = r_opcode;
        w_tx_data_nxt   = r_tx_data;
        w_frame_err_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rx_fire) begin
                    if (bus.rx_data[7:4] == 4'hA && bus.rx_data[3:2] == 2'b00) begin
                        w_opcode_nxt = bus.rx_data[1:0];
                        w_state_nxt  = S_GET_A;
                    end else begin
                        w_frame_err_nxt = 1'b1;
                    end
                end
            end
            S_GET_A, S_GET_B: begin
                // An accepted byte beats a timeout landing on the same edge.
                if (w_rx_fire) begin
                    if (r_state == S_GET_A) begin
                        w_calc_a_nxt = bus.rx_data;
                        w_state_nxt  = S_GET_B;
                    end else begin
                        w_calc_b_nxt = bus.rx_data;
                        w_state_nxt  = S_EXEC;
                    end
                end else if (r_cnt == TIMEOUT_LAST) begin
                    w_frame_err_nxt = 1'b1;
                    w_state_nxt     = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            S_EXEC: begin
                // On divide-by-zero the calculator result is undefined; substitute zero.
                w_err_nxt     = bus.calc_error;
                w_res_nxt     = bus.calc_error ? 16'h0000 : bus.calc_result;
                w_tx_data_nxt = {4'h5, 1'b0, bus.calc_error, r_opcode};
                w_state_nxt   = S_SEND_S;
            end
            S_SEND_S: begin
                if (w_tx_fire) begin
                    w_tx_data_nxt = r_res_q[15:8];
                    w_state_nxt   = S_SEND_H;
                end
            end
            S_SEND_H: begin
                if (w_tx_fire) begin
                    w_tx_data_nxt = r_res_q[7:0];
                    w_state_nxt   = S_SEND_L;
                end
            end
            S_SEND_L: begin
                if (w_tx_fire) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 8'd0;
            r_res_q     <= 16'h0000;
            r_err_q     <= 1'b0;
            r_calc_a    <= 8'd0;
            r_calc_b    <= 8'd0;
            r_opcode    <= 2'd0;
            r_tx_data   <= 8'd0;
            r_tx_valid  <= 1'b0;
            r_rx_ready  <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_res_q     <= w_res_nxt;
            r_err_q     <= w_err_nxt;
            r_calc_a    <= w_calc_a_nxt;
            r_calc_b    <= w_calc_b_nxt;
            r_opcode    <= w_opcode_nxt;
            r_tx_data   <= w_tx_data_nxt;
            r_tx_valid  <= w_state_nxt inside {S_SEND_S, S_SEND_H, S_SEND_L};
            r_rx_ready  <= w_state_nxt inside {S_IDLE, S_GET_A, S_GET_B};
            r_busy      <= (w_state_nxt != S_IDLE);
            r_frame_err <= w_frame_err_nxt;
        end
    end

    assign bus.rx_ready    = r_rx_ready;
    assign bus.tx_data     = r_tx_data;
    assign bus.tx_valid    = r_tx_valid;
    assign bus.calc_a      = r_calc_a;
    assign bus.calc_b      = r_calc_b;
    assign bus.calc_opcode = r_opcode;
    assign bus.busy        = r_busy;
    assign bus.frame_err   = r_frame_err;

endmodule

// File: tb/tb_calc_frame_sequencer.sv
// Scoreboard bench for calc_frame_sequencer: stimulus pushes expected response
// bytes, a negedge monitor pops and compares each accepted tx byte.
`timescale 1ns/1ps
module tb_calc_frame_sequencer;

    logic clk;
    logic rst;
    calc_frame_sequencer_if bus ();

    calc_frame_sequencer #(.IDLE_TIMEOUT(255)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Calculator model; a recognisable junk value on divide-by-zero.
    always_comb begin
        bus.calc_error  = 1'b0;
        bus.calc_result = 16'h0000;
        case (bus.calc_opcode)
            2'b00: bus.calc_result = {8'h00, bus.calc_a} + {8'h00, bus.calc_b};
            2'b01: bus.calc_result = {8'h00, bus.calc_a} - {8'h00, bus.calc_b};
            2'b10: bus.calc_result = {8'h00, bus.calc_a} * {8'h00, bus.calc_b};
            default: begin
                if (bus.calc_b == 8'h00) begin
                    bus.calc_error  = 1'b1;
                    bus.calc_result = 16'hDEAD;
                end else begin
                    bus.calc_result = {8'h00, bus.calc_a / bus.calc_b};
                end
            end
        endcase
    end

    int n_checks = 0;
    int n_fail   = 0;
    int fe_cnt   = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.frame_err) fe_cnt++;
        if (!rst && bus.tx_valid && bus.tx_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL tx_unexpected: got byte %0h, required no byte", bus.tx_data);
            end else begin
                check("tx_byte", {24'h0, bus.tx_data}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bit done;
        done = 1'b0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (bus.rx_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        bus.rx_valid = 1'b0;
        check("rx_accepted", {31'h0, done}, 32'h1);
    endtask

    task automatic wait_done();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.busy) done = 1'b1;
        end
        check("frame_done", {31'h0, done}, 32'h1);
        @(posedge clk);
        #1;
    endtask

    task automatic push3(input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
        exp_q.push_back(e0);
        exp_q.push_back(e1);
        exp_q.push_back(e2);
    endtask

    task automatic run_frame(input logic [7:0] h, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
        push3(e0, e1, e2);
        send_byte(h);
        send_byte(a);
        send_byte(b);
        wait_done();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int fe0;
        clk          = 1'b0;
        rst          = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("rst_tx_valid",  {31'h0, bus.tx_valid},  32'h0);
        check("rst_tx_data",   {24'h0, bus.tx_data},   32'h0);
        check("rst_calc_a",    {24'h0, bus.calc_a},    32'h0);
        check("rst_calc_b",    {24'h0, bus.calc_b},    32'h0);
        check("rst_opcode",    {30'h0, bus.calc_opcode}, 32'h0);
        check("rst_busy",      {31'h0, bus.busy},      32'h0);
        check("rst_frame_err", {31'h0, bus.frame_err}, 32'h0);
        check("rst_rx_ready",  {31'h0, bus.rx_ready},  32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rx_ready_before_edge", {31'h0, bus.rx_ready}, 32'h0);
        @(posedge clk);
        #1;
        check("rx_ready_after_edge", {31'h0, bus.rx_ready}, 32'h1);

        // Add, with latency of the status byte.
        fe0 = fe_cnt;
        push3(8'h50, 8'h00, 8'h46);
        send_byte(8'hA0);
        send_byte(8'h12);
        send_byte(8'h34);
        check("exec_no_tx_valid", {31'h0, bus.tx_valid}, 32'h0);
        check("exec_busy",        {31'h0, bus.busy},     32'h1);
        check("exec_no_rx_ready", {31'h0, bus.rx_ready}, 32'h0);
        @(posedge clk);
        #1;
        check("status_valid_k1", {31'h0, bus.tx_valid}, 32'h1);
        check("status_data_k1",  {24'h0, bus.tx_data},  32'h50);
        wait_done();
        check("add_no_frame_err", fe_cnt, fe0);

        // Mul with 5 stall cycles during SEND_H.
        push3(8'h52, 8'hFE, 8'h01);
        send_byte(8'hA2);
        send_byte(8'hFF);
        send_byte(8'hFF);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("stall_tx_valid", {31'h0, bus.tx_valid}, 32'h1);
            check("stall_tx_data",  {24'h0, bus.tx_data},  32'hFE);
        end
        bus.tx_ready = 1'b1;
        wait_done();

        // Div, then divide by zero.
        run_frame(8'hA3, 8'h64, 8'h07, 8'h53, 8'h00, 8'h0E);
        run_frame(8'hA3, 8'h07, 8'h00, 8'h57, 8'h00, 8'h00);

        // Sub wrap.
        run_frame(8'hA1, 8'h03, 8'h05, 8'h51, 8'hFF, 8'hFE);

        // Bad headers.
        fe0 = fe_cnt;
        send_byte(8'h30);
        send_byte(8'hA4);
        repeat (3) @(posedge clk);
        #1;
        check("bad_hdr_pulses", fe_cnt, fe0 + 2);
        check("bad_hdr_idle",   {31'h0, bus.busy}, 32'h0);

        // Timeout abort after 255 idle cycles in GET_B.
        send_byte(8'hA0);
        send_byte(8'h01);
        fe0 = fe_cnt;
        repeat (254) @(posedge clk);
        #1;
        check("timeout_254_busy", {31'h0, bus.busy}, 32'h1);
        check("timeout_254_fe",   fe_cnt, fe0);
        @(posedge clk);
        #1;
        check("timeout_255_busy",  {31'h0, bus.busy},      32'h0);
        check("timeout_255_pulse", {31'h0, bus.frame_err}, 32'h1);
        @(posedge clk);
        #1;
        check("timeout_pulse_once", {31'h0, bus.frame_err}, 32'h0);
        run_frame(8'hA0, 8'h01, 8'h01, 8'h50, 8'h00, 8'h02);

        // Byte accepted on the 255th idle cycle wins over the abort.
        push3(8'h50, 8'h00, 8'h06);
        send_byte(8'hA0);
        send_byte(8'h01);
        fe0 = fe_cnt;
        repeat (254) @(posedge clk);
        #1;
        send_byte(8'h05);
        check("late_byte_busy", {31'h0, bus.busy}, 32'h1);
        wait_done();
        check("late_byte_no_fe", fe_cnt, fe0);

        // Reset after the status byte is accepted.
        exp_q.push_back(8'h50);
        send_byte(8'hA0);
        send_byte(8'h05);
        send_byte(8'h06);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_tx_valid", {31'h0, bus.tx_valid}, 32'h0);
        check("mid_rst_busy",     {31'h0, bus.busy},     32'h0);
        check("mid_rst_rx_ready", {31'h0, bus.rx_ready}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel_rx_ready_low", {31'h0, bus.rx_ready}, 32'h0);
        @(posedge clk);
        #1;
        check("rel_rx_ready_high", {31'h0, bus.rx_ready}, 32'h1);
        run_frame(8'hA0, 8'h02, 8'h02, 8'h50, 8'h00, 8'h04);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
